// File: rtl/operand_pkg.sv
// Shared types and constants for the five-operand arithmetic front end.
package operand_pkg;

    localparam int unsigned OP_W  = 16;
    localparam int unsigned OP_N  = 5;
    localparam int unsigned IDX_W = $clog2(OP_N);

    typedef logic [OP_W-1:0] op_t;
    typedef op_t [OP_N-1:0] op_set_t;

    typedef enum logic {
        COLLECT = 1'b0,
        RESYNC  = 1'b1
    } framer_state_e;

endpackage

// File: rtl/operand_out_slot.sv
// Registered valid/ready holding stage for one operand set.
module operand_out_slot
    import operand_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  op_set_t set_in,
    input  logic    m_ready,
    output logic    m_valid,
    output op_set_t set_out
);

    logic    valid_q, valid_d;
    op_set_t set_q, set_d;

    // A load in the same cycle as a drain wins, so back-to-back sets leave no bubble.
    always_comb begin
        valid_d = valid_q;
        set_d   = set_q;
        if (valid_q && m_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            set_d   = set_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            set_q   <= '0;
        end else begin
            valid_q <= valid_d;
            set_q   <= set_d;
        end
    end

    assign m_valid = valid_q;
    assign set_out = set_q;

endmodule

// File: rtl/operand_framer.sv
// Frames a serial word stream into five-operand sets; drops and resyncs on malformed frames.
// Optional OPERAND_FRAMER_FRAME_CNT_EN adds frame_cnt / err_cnt statistics outputs.
module operand_framer
    import operand_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [OP_W-1:0] s_data,
    input  logic            s_last,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [OP_W-1:0] m_in1,
    output logic [OP_W-1:0] m_in2,
    output logic [OP_W-1:0] m_in3,
    output logic [OP_W-1:0] m_in4,
    output logic [OP_W-1:0] m_in5,
    output logic            frame_err
`ifdef OPERAND_FRAMER_FRAME_CNT_EN
    ,
    output logic [15:0]     frame_cnt,
    output logic [7:0]      err_cnt
`endif
);

    framer_state_e    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    op_set_t          collect_q, collect_d;
    logic             frame_err_q, frame_err_d;
    logic             load_c;
    logic             s_ready_c;
    logic             last_slot_c;
    logic             slot_valid;
    op_set_t          slot_set;

    assign last_slot_c = (idx_q == IDX_W'(OP_N - 1));
    // Only the closing word stalls, and only while the previous set is still waiting.
    assign s_ready_c   = !(state_q == COLLECT && last_slot_c && slot_valid && !m_ready);
    assign s_ready     = s_ready_c;

    // Framing FSM: collect words, validate s_last position, resync after long frames.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        collect_d   = collect_q;
        frame_err_d = 1'b0;
        load_c      = 1'b0;
        if (s_valid && s_ready_c) begin
            case (state_q)
                COLLECT: begin
                    collect_d[idx_q] = s_data;
                    if (last_slot_c) begin
                        idx_d = '0;
                        if (s_last) begin
                            load_c = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = RESYNC;
                        end
                    end else if (s_last) begin
                        idx_d       = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                RESYNC: begin
                    if (s_last) begin
                        state_d = COLLECT;
                        idx_d   = '0;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            collect_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            collect_q   <= collect_d;
            frame_err_q <= frame_err_d;
        end
    end

    // collect_d already holds the closing word in its slot when load_c fires.
    operand_out_slot u_out_slot (
        .clk     (clk),
        .rst     (rst),
        .load    (load_c),
        .set_in  (collect_d),
        .m_ready (m_ready),
        .m_valid (slot_valid),
        .set_out (slot_set)
    );

    assign m_valid   = slot_valid;
    assign m_in1     = slot_set[0];
    assign m_in2     = slot_set[1];
    assign m_in3     = slot_set[2];
    assign m_in4     = slot_set[3];
    assign m_in5     = slot_set[4];
    assign frame_err = frame_err_q;

`ifdef OPERAND_FRAMER_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    // Frame count wraps; error count saturates.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (slot_valid && m_ready) begin
            frame_cnt_d = frame_cnt_q + 16'(1);
        end
        if (frame_err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_operand_framer.sv
// Self-checking bench for operand_framer: directed frames plus randomized traffic against a frame-level model.
module tb_operand_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_in1, m_in2, m_in3, m_in4, m_in5;
    logic        frame_err;
`ifdef OPERAND_FRAMER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`endif

    always #5 clk = ~clk;

    operand_framer dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_in1     (m_in1),
        .m_in2     (m_in2),
        .m_in3     (m_in3),
        .m_in4     (m_in4),
        .m_in5     (m_in5),
        .frame_err (frame_err)
`ifdef OPERAND_FRAMER_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame-level reference: words of the open frame, resync flag, pending output set.
    logic [15:0] mq[$];
    bit          m_resync;
    bit          e_valid;
    logic [15:0] e_set[5];
    bit          e_err;
    int unsigned e_fcnt;
    int unsigned e_ecnt;

    function automatic logic [79:0] exp_pack();
        return {e_set[4], e_set[3], e_set[2], e_set[1], e_set[0]};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_resync = 0;
        e_valid  = 0;
        e_err    = 0;
        e_fcnt   = 0;
        e_ecnt   = 0;
        foreach (e_set[k]) e_set[k] = 16'h0;
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, advance the model across the edge.
    task automatic cycle(input logic v, input logic [15:0] d, input logic last,
                         input logic mr, output bit acc);
        bit e_rdy;
        bit in_x;
        bit out_x;
        s_valid = v;
        s_data  = d;
        s_last  = last;
        m_ready = mr;
        @(negedge clk);
        e_rdy = !(!m_resync && mq.size() == 4 && e_valid && !mr);
        check_eq("s_ready", 80'(s_ready), 80'(e_rdy));
        check_eq("m_valid", 80'(m_valid), 80'(e_valid));
        check_eq("m_in", {m_in5, m_in4, m_in3, m_in2, m_in1}, exp_pack());
        check_eq("frame_err", 80'(frame_err), 80'(e_err));
`ifdef OPERAND_FRAMER_FRAME_CNT_EN
        check_eq("frame_cnt", 80'(frame_cnt), 80'(e_fcnt & 32'hFFFF));
        check_eq("err_cnt", 80'(err_cnt), 80'(e_ecnt));
`endif
        in_x  = v && e_rdy;
        out_x = e_valid && mr;
        e_err = 0;
        if (out_x) begin
            e_valid = 0;
            e_fcnt  = e_fcnt + 1;
        end
        if (in_x) begin
            if (m_resync) begin
                if (last) m_resync = 0;
            end else begin
                mq.push_back(d);
                if (mq.size() == 5) begin
                    if (last) begin
                        foreach (e_set[k]) e_set[k] = mq[k];
                        e_valid = 1;
                    end else begin
                        e_err    = 1;
                        m_resync = 1;
                    end
                    mq.delete();
                end else if (last) begin
                    e_err = 1;
                    mq.delete();
                end
            end
        end
        if (e_err && e_ecnt < 255) e_ecnt++;
        acc = in_x;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] base, input int len, input bit with_last, input logic mr);
        for (int i = 0; i < len; i++) begin
            bit acc = 0;
            int tries = 0;
            while (!acc) begin
                cycle(1'b1, base + 16'(i), (with_last && i == len - 1), mr, acc);
                tries++;
                if (!acc && tries > 20) begin
                    check_eq("send_timeout", 80'(0), 80'(1));
                    return;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 1'b1, acc);
    endtask

    task automatic do_reset();
        s_valid = 0;
        rst     = 1;
        #1;
        check_eq("rst_m_valid", 80'(m_valid), 80'(0));
        check_eq("rst_m_in", {m_in5, m_in4, m_in3, m_in2, m_in1}, 80'(0));
        check_eq("rst_frame_err", 80'(frame_err), 80'(0));
        model_reset();
        @(negedge clk);
        rst = 0;
        check_eq("rst_s_ready", 80'(s_ready), 80'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int plans[10] = '{5, 5, 5, 5, 3, 7, 1, 6, 4, 2};
        int plan;
        int pos;

        rst     = 1;
        s_valid = 0;
        s_data  = 0;
        s_last  = 0;
        m_ready = 1;
        model_reset();
        #7;
        check_eq("init_m_valid", 80'(m_valid), 80'(0));
        check_eq("init_m_in", {m_in5, m_in4, m_in3, m_in2, m_in1}, 80'(0));
        check_eq("init_s_ready", 80'(s_ready), 80'(1));
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // Good frame 1..5
        send(16'h0001, 5, 1, 1'b1);
        idle(2);

        // Backpressure: second frame's final word stalls, then reloads with no bubble
        send(16'h0010, 5, 1, 1'b0);
        send(16'h0020, 4, 0, 1'b0);
        cycle(1'b1, 16'h0024, 1'b1, 1'b0, acc);
        cycle(1'b1, 16'h0024, 1'b1, 1'b1, acc);
        idle(2);

        // Short frame followed by good frame
        send(16'h0030, 3, 1, 1'b1);
        send(16'h000A, 5, 1, 1'b1);
        idle(2);

        // Long frame followed by good frame
        send(16'h0040, 7, 1, 1'b1);
        send(16'h0050, 5, 1, 1'b1);
        idle(2);

        // Reset mid-frame and with a pending set
        send(16'h0060, 2, 0, 1'b1);
        do_reset();
        send(16'h0070, 5, 1, 1'b0);
        do_reset();
        send(16'h0080, 5, 1, 1'b1);
        idle(2);

        // Randomized traffic with mixed frame lengths and backpressure
        pos  = 0;
        plan = plans[$urandom_range(0, 9)];
        for (int c = 0; c < 800; c++) begin
            logic v;
            logic last;
            v    = ($urandom_range(0, 3) != 0);
            last = (pos == plan - 1);
            cycle(v, 16'($urandom), last, ($urandom_range(0, 2) != 0), acc);
            if (acc) begin
                if (last) begin
                    pos  = 0;
                    plan = plans[$urandom_range(0, 9)];
                end else begin
                    pos++;
                end
            end
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_framer.md
Name: operand_framer

Overview:
- Upstream feeder for the five-operand arithmetic stage (inputs in1..in5, 16 bit each).
- Accepts a serial stream of 16-bit words with valid/ready and s_last framing.
- Assembles each 5-word frame into a parallel operand set and presents it on a registered valid/ready output port.
- Detects malformed frames, discards them and resynchronises on the next s_last.

Parameters:
- W, 16, operand width in bits.
- N, 5, words per frame; fixed at 5 for this design, legal range 2..8.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  framer can accept a word this cycle.
- s_data  in  W  input word; word k of a frame maps to operand in(k+1).
- s_last  in  1  marks the final word of a frame.
- m_valid  out  1  operand set valid.
- m_ready  in  1  arithmetic stage accepts the operand set.
- m_in1..m_in5  out  W each  operand set, fed directly to in1..in5.
- frame_err  out  1  one-cycle pulse when a malformed frame is dropped.

Behaviour:
- Reset (asynchronous, active-high): state=COLLECT, idx=0, m_valid=0, m_in1..m_in5=0, frame_err=0, collect registers=0. s_ready is combinational and equals 1 after reset.
- Transfer rules:
  - Input word transfers when s_valid && s_ready.
  - Output set transfers when m_valid && m_ready.
- State COLLECT:
  - On each transfer, the word is stored in collect slot idx and idx increments.
  - Transfer at idx<N-1 with s_last=1: short frame. Drop the partial set, pulse frame_err, idx=0, stay in COLLECT.
  - Transfer at idx=N-1 with s_last=1: frame complete. Load all N slots into the m_in registers (slot idx takes s_data directly), m_valid=1 next cycle, idx=0.
  - Transfer at idx=N-1 with s_last=0: long frame. Pulse frame_err, idx=0, go to RESYNC.
- State RESYNC:
  - s_ready=1; all words are dropped.
  - Transfer with s_last=1 returns to COLLECT with idx=0. No further frame_err pulse.
- Output slot:
  - m_in1..m_in5 and m_valid are registered.
  - Values are held stable while m_valid && !m_ready.
  - m_valid clears on an output transfer unless a new frame completes in the same cycle.
- Backpressure:
  - s_ready = !(state==COLLECT && idx==N-1 && m_valid && !m_ready).
  - Only the final word stalls. Words 0..N-2 of the next frame are collected while the previous set waits.
- Simultaneous events: completing a frame in the same cycle as an output transfer reloads the slot with no bubble, and m_valid stays 1.
- Throughput: one frame per N cycles sustained.
- Latency: last-word acceptance to m_valid is 1 cycle.
- Width: no arithmetic; data is passed unmodified and unsigned.
- Reset mid-frame: the partial frame is lost and the pending output is cleared. No frame_err pulse on reset.

Optional Feature:
- Macro: OPERAND_FRAMER_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt (out, 16).
  - Counts output transfers; wraps 0xFFFF->0; reset value 0.
  - Adds output err_cnt (out, 8).
  - Counts frame_err pulses; saturates at 0xFF; reset value 0.
- Undefined: neither port nor the counter logic exists. All other behaviour is identical.

Decomposition:
- Shared package operand_pkg:
  - constants OP_W=16 and OP_N=5.
  - typedef op_t (logic [OP_W-1:0]).
  - typedef op_set_t (array of OP_N op_t).
  - framer state enum {COLLECT, RESYNC}.
- One natural sub-module: operand_out_slot. It is the registered valid/ready holding stage for an op_set_t, with load/hold/clear logic.
- Collection and framing FSM stay in operand_framer.

Test Plan:
- Good frame: words 0x0001,0x0002,0x0003,0x0004,0x0005 (s_last on 5th), m_ready=1 -> m_valid one cycle after the 5th word; m_in1..m_in5=1..5; frame_err=0.
- Backpressure: two back-to-back frames with m_ready=0 -> 2nd frame words 1–4 accepted; s_ready=0 at the 5th word. Raise m_ready -> first set (1..5) transfers; second set appears next cycle with no lost word.
- Short frame: 3 words with s_last on the 3rd, then a good frame 0xA..0xE -> frame_err pulses once; next output is 0xA..0xE.
- Long frame: 7 words, s_last on the 7th, then a good frame -> frame_err pulses at the 5th word; words 6–7 are dropped; next output is the good frame.
- Reset mid-frame: assert rst after word 2, and also while m_valid=1 -> m_valid=0 and all m_in=0 immediately. A following good frame is delivered correctly.
- With OPERAND_FRAMER_FRAME_CNT_EN: 3 good frames plus 1 short frame -> frame_cnt=3, err_cnt=1.
